// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read, writeback bypass, scoreboard hazard stall,
// and a registered valid/ready slot that hands resolved operands to execute.
module operand_fetch #(
    parameter int WIDTH      = 32,
    parameter int REG_COUNT  = 32,
    parameter int INFO_WIDTH = 64,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_rs1,
    input  logic [AW-1:0]         in_rs2,
    input  logic [AW-1:0]         in_rd,
    input  logic                  in_rd_en,
    input  logic [INFO_WIDTH-1:0] in_info,
    output logic [AW-1:0]         rf_read_addr [2],
    output logic                  rf_read_enable [2],
    input  logic [WIDTH-1:0]      rf_read_data [2],
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_rs1_data,
    output logic [WIDTH-1:0]      out_rs2_data,
    output logic [AW-1:0]         out_rd,
    output logic                  out_rd_en,
    output logic [INFO_WIDTH-1:0] out_info,
    output logic [31:0]           stall_count
);

    logic [REG_COUNT-1:0] pending;
    logic                 hazard;
    logic                 accept;
    logic                 issue;
    logic                 wb_clear;

    function automatic logic wb_hit(input logic [AW-1:0] r);
        return wb_valid && (wb_addr == r) && (r != '0);
    endfunction

    // A register is busy while its writer is in flight (unless it writes back
    // right now) or while its writer still sits in our own output slot.
    function automatic logic busy(input logic [AW-1:0] r);
        return (r != '0) &&
               ((pending[r] && !wb_hit(r)) || (out_valid && out_rd_en && (out_rd == r)));
    endfunction

    function automatic logic [WIDTH-1:0] resolve(input logic [AW-1:0] r,
                                                 input logic [WIDTH-1:0] rf);
        if (r == '0)
            return '0;
        if (wb_hit(r))
            return wb_data;
        return rf;
    endfunction

    always_comb begin
        rf_read_addr[0]   = in_rs1;
        rf_read_addr[1]   = in_rs2;
        rf_read_enable[0] = in_valid;
        rf_read_enable[1] = in_valid;
    end

    assign hazard   = in_valid && (busy(in_rs1) || busy(in_rs2) || (in_rd_en && busy(in_rd)));
    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid && out_ready && !flush && out_rd_en && (out_rd != '0);
    assign wb_clear = wb_valid && (wb_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_en    <= 1'b0;
            out_info     <= '0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_rs1_data <= resolve(in_rs1, rf_read_data[0]);
            out_rs2_data <= resolve(in_rs2, rf_read_data[1]);
            out_rd       <= in_rd;
            out_rd_en    <= in_rd_en;
            out_info     <= in_info;
        end else if (out_valid && (out_ready || flush)) begin
            out_valid    <= 1'b0;
        end
    end

    // Bit 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (issue && (out_rd == AW'(i)))
                    pending[i] <= 1'b1;
                else if (wb_clear && (wb_addr == AW'(i)))
                    pending[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (hazard && !flush && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

endmodule
